// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word read at a time to the
// instruction pool and hands the returned word to decode over valid/ready.
module fetch_unit #(
    parameter int          READ_ADDR_SIZE = 28,
    parameter int          ROW_WIDTH      = 32,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startSig,
    input  logic                      redirectEn,
    input  logic [31:0]               redirectPc,
    output logic [READ_ADDR_SIZE-1:0] memReadAddr,
    output logic                      memReadEn,
    input  logic                      memReadFin,
    input  logic [ROW_WIDTH-1:0]      memReadData,
    output logic                      instValid,
    output logic [ROW_WIDTH-1:0]      instData,
    output logic [31:0]               instPc,
    input  logic                      decReady,
    output logic                      fetchFault,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        FLUSH = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   inst_valid_q, inst_valid_d;
    logic [ROW_WIDTH-1:0]   inst_data_q, inst_data_d;
    logic [31:0]            inst_pc_q, inst_pc_d;
    logic                   fault_q, fault_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= {ROW_WIDTH{1'b0}};
            inst_pc_q    <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state logic; a redirect outside IDLE pre-empts every other transition.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;

        if (redirectEn && (state_q != IDLE)) begin
            pc_d         = redirectPc;
            inst_valid_d = 1'b0;
            if (redirectPc[1:0] == 2'b00) begin
                state_d = FLUSH;
                fault_d = 1'b0;
            end else begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (startSig) begin
                        pc_d    = RESET_PC;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REQ: begin
                    if (memReadFin) begin
                        inst_data_d  = memReadData;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end
                HOLD: begin
                    if (decReady) begin
                        inst_valid_d = 1'b0;
                        state_d      = REQ;
                    end else begin
                        state_d = HOLD;
                    end
                end
                // Response to the pre-redirect address may land here; it is dropped.
                FLUSH:   state_d = REQ;
                FAULT:   state_d = FAULT;
                default: begin
                    state_d      = IDLE;
                    inst_valid_d = 1'b0;
                    fault_d      = 1'b0;
                end
            endcase
        end
    end

    assign memReadEn   = (state_q == REQ);
    assign memReadAddr = pc_q[READ_ADDR_SIZE+1:2];
    assign instValid   = inst_valid_q;
    assign instData    = inst_data_q;
    assign instPc      = inst_pc_q;
    assign fetchFault  = fault_q;
    assign busy        = (state_q != IDLE);

endmodule
